// File: rtl/regfile_writeback_if.sv
// -----------------------------------------------------------------------------
// regfile_writeback_if
//   Bundle of the handshake, write-port and hazard-query signals used by the
//   register-file write-back front end.
//
//   master : producer/consumer side (drives results, hold and chk_addr;
//            observes ready, write port, busy, chk_busy and count)
//   slave  : the write-back block itself
//
//   Signals
//     alu_valid/alu_addr/alu_data/alu_ready : ALU result handshake
//     id_valid/id_addr/id_data/id_ready     : decoder result handshake
//     hold                                  : stall draining (queue keeps filling)
//     write_addr/write_value_alu/write_value_id/write_data_sel/write_enable
//                                           : registered register-file write port
//     busy                                  : per-register pending-write flags
//     chk_addr/chk_busy                     : single-register hazard query
//     count                                 : queue occupancy
// -----------------------------------------------------------------------------
interface regfile_writeback_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NREG  = 1 << ADDR_W;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              id_valid;
  logic [ADDR_W-1:0] id_addr;
  logic [DATA_W-1:0] id_data;
  logic              id_ready;

  logic              hold;

  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_value_alu;
  logic [DATA_W-1:0] write_value_id;
  logic              write_data_sel;
  logic              write_enable;

  logic [NREG-1:0]   busy;
  logic [ADDR_W-1:0] chk_addr;
  logic              chk_busy;
  logic [CNT_W-1:0]  count;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output id_valid, id_addr, id_data,
    output hold, chk_addr,
    input  alu_ready, id_ready,
    input  write_addr, write_value_alu, write_value_id, write_data_sel, write_enable,
    input  busy, chk_busy, count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  id_valid, id_addr, id_data,
    input  hold, chk_addr,
    output alu_ready, id_ready,
    output write_addr, write_value_alu, write_value_id, write_data_sel, write_enable,
    output busy, chk_busy, count
  );
endinterface

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
//   Writer-side front end of the 8x32 general register file. Accepts results
//   from the ALU and the instruction decoder, arbitrates fairly between them,
//   queues them in order and drives the register-file write port at one write
//   per cycle. A per-register pending counter tracks every accepted write until
//   the register file has captured it, for hazard checks.
//
//   Ports
//     clk  : system clock, all state on the rising edge
//     rst  : synchronous active-high reset
//     bus  : regfile_writeback_if.slave (handshakes, write port, busy,
//            chk_addr/chk_busy, count)
//
//   Optional feature (macro WB_BYPASS_EN)
//     When defined, a result accepted while the queue is empty and hold is low
//     goes straight into the write-port registers, skipping the queue.
// -----------------------------------------------------------------------------
module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  regfile_writeback_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PEND_W = $clog2(DEPTH + 2);
  localparam int NREG   = 1 << ADDR_W;

  typedef struct packed {
    logic              src;   // 1 = ALU, 0 = decoder
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Queue storage and pointers (extra MSB is the wrap bit)
  entry_t            mem_q [DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;

  // Arbiter preference: 1 = ALU wins the next contested cycle
  logic              pref_alu_q, pref_alu_d;

  // Write-port output registers
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              wsel_q, wsel_d;
  logic [DATA_W-1:0] wval_alu_q, wval_alu_d;
  logic [DATA_W-1:0] wval_id_q, wval_id_d;

  // Scoreboard
  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic [NREG-1:0]   busy_vec;

  logic [CNT_W-1:0]  count;
  logic              space, contested;
  logic              alu_acc, id_acc, push, pop, bypass, load_out;
  entry_t            in_entry, head, out_entry;

  assign count     = wr_ptr_q - rd_ptr_q;
  // Space ignores a same-cycle pop so ready never depends on hold.
  assign space     = (count < CNT_W'(DEPTH));
  assign contested = bus.alu_valid && bus.id_valid;

  assign bus.alu_ready = space && (!contested || pref_alu_q);
  assign bus.id_ready  = space && (!contested || !pref_alu_q);

  assign alu_acc  = bus.alu_valid && bus.alu_ready;
  assign id_acc   = bus.id_valid && bus.id_ready;
  assign push     = alu_acc || id_acc;
  assign in_entry = alu_acc ? {1'b1, bus.alu_addr, bus.alu_data}
                            : {1'b0, bus.id_addr, bus.id_data};

  assign head = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign pop  = !bus.hold && (count != '0);

`ifdef WB_BYPASS_EN
  assign bypass = push && (count == '0) && !bus.hold;
`else
  assign bypass = 1'b0;
`endif

  // pop and bypass are mutually exclusive: bypass needs an empty queue.
  assign load_out  = pop || bypass;
  assign out_entry = bypass ? in_entry : head;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pref_alu_d = pref_alu_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wsel_d     = wsel_q;
    wval_alu_d = wval_alu_q;
    wval_id_d  = wval_id_q;

    // Preference flips only after a contested grant, giving strict alternation.
    if (contested && space) pref_alu_d = !pref_alu_q;

    if (push && !bypass) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (pop)             rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);

    if (load_out) begin
      we_d       = 1'b1;
      waddr_d    = out_entry.addr;
      wsel_d     = out_entry.src;
      wval_alu_d = out_entry.src ? out_entry.data : '0;
      wval_id_d  = out_entry.src ? '0 : out_entry.data;
    end

    // Increment on accept, decrement when the register file captures the
    // write (the edge on which write_enable is high); both cancel out.
    for (int r = 0; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
      if (push && (in_entry.addr == ADDR_W'(r)))
        pend_d[r] = pend_d[r] + PEND_W'(1);
      if (we_q && (waddr_q == ADDR_W'(r)))
        pend_d[r] = pend_d[r] - PEND_W'(1);
      busy_vec[r] = (pend_q[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pref_alu_q <= 1'b1;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wsel_q     <= 1'b0;
      wval_alu_q <= '0;
      wval_id_q  <= '0;
      for (int r = 0; r < NREG; r++) pend_q[r] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pref_alu_q <= pref_alu_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wsel_q     <= wsel_d;
      wval_alu_q <= wval_alu_d;
      wval_id_q  <= wval_id_d;
      for (int r = 0; r < NREG; r++) pend_q[r] <= pend_d[r];
    end
  end

  // NOTE: queue storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push && !bypass) mem_q[wr_ptr_q[PTR_W-1:0]] <= in_entry;
  end

  assign bus.write_enable    = we_q;
  assign bus.write_addr      = waddr_q;
  assign bus.write_data_sel  = wsel_q;
  assign bus.write_value_alu = wval_alu_q;
  assign bus.write_value_id  = wval_id_q;
  assign bus.busy            = busy_vec;
  assign bus.chk_busy        = busy_vec[bus.chk_addr];
  assign bus.count           = count;

endmodule

// File: tb/tb_regfile_writeback.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback
//   Self-checking bench for regfile_writeback. A transaction-level model (a
//   queue of pending writes, a preference bit and per-register pending counts)
//   predicts ready, the write port, count and busy every cycle. Directed tables
//   and sequences cover reset, alternation, full/hold, latency, hazards and
//   reset mid-operation; a randomized phase follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_writeback;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int NREG   = 1 << ADDR_W;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
  localparam int WE_K   = 0;  // edges after acceptance edge until write_enable
`else
  localparam bit BYPASS = 1'b0;
  localparam int WE_K   = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_writeback_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit              src;
    bit [ADDR_W-1:0] addr;
    bit [DATA_W-1:0] data;
  } wr_t;

  wr_t             mq[$];
  bit              m_pref_alu;
  int              m_pend [NREG];
  bit              m_we;
  bit [ADDR_W-1:0] m_addr;
  bit              m_sel;
  bit [DATA_W-1:0] m_va, m_vi;
  bit              last_alu_acc, last_id_acc;
  logic            pre_alu_rdy, pre_id_rdy;

  function automatic void model_reset();
    mq.delete();
    m_pref_alu = 1'b1;
    foreach (m_pend[r]) m_pend[r] = 0;
    m_we = 0; m_addr = '0; m_sel = 0; m_va = '0; m_vi = '0;
    last_alu_acc = 0; last_id_acc = 0;
  endfunction

  function automatic void model_ready(output bit ar, output bit ir);
    bit space;
    space = (mq.size() < DEPTH);
    if (bus.alu_valid && bus.id_valid) begin
      ar = space && m_pref_alu;
      ir = space && !m_pref_alu;
    end else begin
      ar = space;
      ir = space;
    end
  endfunction

  function automatic void emit(input wr_t e);
    m_we   = 1;
    m_addr = e.addr;
    m_sel  = e.src;
    m_va   = e.src ? e.data : '0;
    m_vi   = e.src ? '0 : e.data;
  endfunction

  function automatic void model_edge(input bit ar, input bit ir);
    wr_t e;
    bit  got, bypassed;
    if (rst) begin
      model_reset();
      return;
    end
    last_alu_acc = bus.alu_valid && ar;
    last_id_acc  = bus.id_valid && ir;
    got = last_alu_acc || last_id_acc;
    if (bus.alu_valid && bus.id_valid && got) m_pref_alu = !m_pref_alu;
    if (m_we) m_pend[m_addr]--;             // register file captures this write
    if (last_alu_acc) e = '{1'b1, bus.alu_addr, bus.alu_data};
    else              e = '{1'b0, bus.id_addr, bus.id_data};
    m_we = 0;
    bypassed = 0;
    if (!bus.hold && mq.size() > 0) emit(mq.pop_front());
    else if (BYPASS && got && !bus.hold) begin
      emit(e);
      bypassed = 1;
    end
    if (got && !bypassed) mq.push_back(e);
    if (got) m_pend[e.addr]++;
  endfunction

  // One clock: inputs are already driven (at the falling edge).
  task automatic tick();
    bit ar, ir;
    logic [NREG-1:0] eb;
    #1;
    model_ready(ar, ir);
    pre_alu_rdy = bus.alu_ready;
    pre_id_rdy  = bus.id_ready;
    check("alu_ready", bus.alu_ready, ar);
    check("id_ready", bus.id_ready, ir);
    model_edge(ar, ir);
    @(posedge clk);
    #1;
    for (int r = 0; r < NREG; r++) eb[r] = (m_pend[r] != 0);
    check("write_enable", bus.write_enable, m_we);
    check("write_addr", bus.write_addr, m_addr);
    check("write_data_sel", bus.write_data_sel, m_sel);
    check("write_value_alu", bus.write_value_alu, m_va);
    check("write_value_id", bus.write_value_id, m_vi);
    check("count", bus.count, mq.size());
    check("busy", bus.busy, eb);
    check("chk_busy", bus.chk_busy, m_pend[bus.chk_addr] != 0);
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit              av, iv, hold;
    bit              ar, ir;
    bit              we;
    bit [ADDR_W-1:0] addr;
    bit              sel;
    bit [DATA_W-1:0] va, vi;
    int              cnt;
  } vec_t;

  vec_t vt [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.alu_valid = 0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.id_valid  = 0; bus.id_addr  = '0; bus.id_data  = '0;
    bus.hold = 0; bus.chk_addr = '0;
    model_reset();

    // --- reset state ---
    @(negedge clk);
    @(negedge clk);
    check("rst write_enable", bus.write_enable, 0);
    check("rst write_addr", bus.write_addr, 0);
    check("rst write_value_alu", bus.write_value_alu, 0);
    check("rst write_value_id", bus.write_value_id, 0);
    check("rst write_data_sel", bus.write_data_sel, 0);
    check("rst busy", bus.busy, 0);
    check("rst count", bus.count, 0);
    bus.alu_valid = 1;
    tick();
    check("rst alu_ready", pre_alu_rdy, 1);
    bus.alu_valid = 0; bus.id_valid = 1;
    tick();
    check("rst id_ready", pre_id_rdy, 1);
    bus.id_valid = 0;
    rst = 1'b0;

    // --- contested alternation under hold, full, then in-order drain ---
    vt[0] = '{1,1,1, 1,0, 0,0,0, 32'h0,        32'h0,        1};
    vt[1] = '{1,1,1, 0,1, 0,0,0, 32'h0,        32'h0,        2};
    vt[2] = '{1,1,1, 1,0, 0,0,0, 32'h0,        32'h0,        3};
    vt[3] = '{1,1,1, 0,1, 0,0,0, 32'h0,        32'h0,        4};
    vt[4] = '{1,1,1, 0,0, 0,0,0, 32'h0,        32'h0,        4};
    vt[5] = '{0,0,0, 0,0, 1,1,1, 32'h11111111, 32'h0,        3};
    vt[6] = '{0,0,0, 1,1, 1,2,0, 32'h0,        32'h22222222, 2};
    vt[7] = '{0,0,0, 1,1, 1,1,1, 32'h11111111, 32'h0,        1};
    vt[8] = '{0,0,0, 1,1, 1,2,0, 32'h0,        32'h22222222, 0};
    vt[9] = '{0,0,0, 1,1, 0,2,0, 32'h0,        32'h22222222, 0};
    bus.alu_addr = 3'd1; bus.alu_data = 32'h11111111;
    bus.id_addr  = 3'd2; bus.id_data  = 32'h22222222;
    for (int i = 0; i < 10; i++) begin
      bus.alu_valid = vt[i].av; bus.id_valid = vt[i].iv; bus.hold = vt[i].hold;
      tick();
      check($sformatf("vec%0d alu_ready", i), pre_alu_rdy, vt[i].ar);
      check($sformatf("vec%0d id_ready", i), pre_id_rdy, vt[i].ir);
      check($sformatf("vec%0d write_enable", i), bus.write_enable, vt[i].we);
      check($sformatf("vec%0d write_addr", i), bus.write_addr, vt[i].addr);
      check($sformatf("vec%0d write_data_sel", i), bus.write_data_sel, vt[i].sel);
      check($sformatf("vec%0d write_value_alu", i), bus.write_value_alu, vt[i].va);
      check($sformatf("vec%0d write_value_id", i), bus.write_value_id, vt[i].vi);
      check($sformatf("vec%0d count", i), bus.count, vt[i].cnt);
    end
    bus.alu_valid = 0; bus.id_valid = 0; bus.hold = 0;

    // --- single ALU write latency and busy window ---
    bus.alu_addr = 3'd3; bus.alu_data = 32'hDEADBEEF; bus.chk_addr = 3'd3;
    for (int k = 0; k < 4; k++) begin
      bus.alu_valid = (k == 0);
      tick();
      if (k == 0) check("lat accept", pre_alu_rdy, 1);
      check($sformatf("lat we k%0d", k), bus.write_enable, k == WE_K);
      check($sformatf("lat busy3 k%0d", k), bus.busy[3], k <= WE_K);
      if (k == WE_K) begin
        check("lat addr", bus.write_addr, 3);
        check("lat sel", bus.write_data_sel, 1);
        check("lat value_alu", bus.write_value_alu, 32'hDEADBEEF);
        check("lat value_id", bus.write_value_id, 0);
      end
    end
    bus.alu_valid = 0;

    // --- hold: five decoder results, only four fit ---
    bus.hold = 1;
    for (int i = 0; i < 5; i++) begin
      bus.id_valid = 1; bus.id_addr = ADDR_W'(i); bus.id_data = 32'hA0000000 + i;
      tick();
      check($sformatf("full id_ready %0d", i), pre_id_rdy, i < 4);
    end
    check("full count", bus.count, 4);
    bus.hold = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (last_id_acc) bus.id_valid = 0;
      check($sformatf("drain we %0d", k), bus.write_enable, 1);
      check($sformatf("drain addr %0d", k), bus.write_addr, k);
      check($sformatf("drain value_id %0d", k), bus.write_value_id, 32'hA0000000 + k);
    end
    bus.id_valid = 0;
    tick();
    check("drain done we", bus.write_enable, 0);

    // --- back-to-back writes to r5, including same-edge inc/dec ---
    bus.chk_addr = 3'd5; bus.alu_addr = 3'd5;
    for (int k = 0; k < 6; k++) begin
      bus.alu_valid = (k < 3); bus.alu_data = 32'h5500 + k;
      tick();
      check($sformatf("r5 chk_busy k%0d", k), bus.chk_busy, k <= 2 + WE_K);
    end
    bus.alu_valid = 0;

    // --- reset with three queued entries and a write in flight ---
    bus.hold = 1;
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1; bus.alu_addr = ADDR_W'(i + 4); bus.alu_data = 32'hC0 + i;
      tick();
    end
    bus.alu_valid = 0; bus.hold = 0;
    tick();
    check("pre-rst we", bus.write_enable, 1);
    check("pre-rst count", bus.count, 3);
    rst = 1;
    tick();
    check("mid-rst we", bus.write_enable, 0);
    check("mid-rst busy", bus.busy, 0);
    check("mid-rst count", bus.count, 0);
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("post-rst we %0d", k), bus.write_enable, 0);
    end

    // --- randomized traffic against the model ---
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.hold = ($urandom_range(0, 9) < 3);
      if (!bus.alu_valid || last_alu_acc) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_addr  = ADDR_W'($urandom_range(0, NREG - 1));
        bus.alu_data  = $urandom;
      end
      if (!bus.id_valid || last_id_acc) begin
        bus.id_valid = 1'($urandom_range(0, 1));
        bus.id_addr  = ADDR_W'($urandom_range(0, NREG - 1));
        bus.id_data  = $urandom;
      end
      bus.chk_addr = ADDR_W'($urandom_range(0, NREG - 1));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
